// File: rtl/mem_sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_sram_ctrl_if
// Request/response bus between the MEM pipeline stage and the SRAM controller.
//   req_valid  MEM stage presents a request
//   req_we     1 = write, 0 = read
//   req_addr   18-bit word address
//   req_wdata  16-bit write data
//   req_be     write byte enables: [1] = upper byte, [0] = lower byte
//   req_ready  controller can accept a request this cycle
//   rsp_valid  one-cycle pulse, read data valid
//   rsp_rdata  read data, held until the next read completes
// master = MEM stage side, slave = controller side.
// ---------------------------------------------------------------------------
interface mem_sram_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [17:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_sram_ctrl
// Memory-stage controller that turns single-beat word reads/writes into
// asynchronous 16-bit SRAM bus cycles, stalling the pipeline via req_ready
// while an access is in flight.
//   CLOCK_50   system clock (rising edge)
//   reset      synchronous, active-high
//   bus        request/response bus (slave side)
//   SRAM_DQ    bidirectional SRAM data bus
//   SRAM_ADDR  SRAM word address
//   SRAM_*_N   active-low SRAM strobes (WE, OE, UB, LB, CE)
// Parameters:
//   RD_WAIT    cycles OE_N/CE_N low before read data is sampled (1..15)
//   WR_WAIT    cycles WE_N held low during a write (1..15)
// ---------------------------------------------------------------------------
module mem_sram_ctrl #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  mem_sram_ctrl_if.slave    bus,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [17:0]       SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_CE_N
);

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [17:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic [1:0]  be_reg, be_next;
  logic [15:0] rdata_reg, rdata_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        accept;
  logic        dq_oe;

  // Ready depends on reset directly so nothing is accepted while reset is held.
  assign bus.req_ready = (state_reg == IDLE) && !reset;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rdata_reg;
  assign accept        = bus.req_valid && bus.req_ready;

  // Next-state logic. The request is latched on accept, so later changes
  // on req_* have no effect on the access in flight.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    be_next        = be_reg;
    rdata_next     = rdata_reg;
    rsp_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          addr_next  = bus.req_addr;
          wdata_next = bus.req_wdata;
          be_next    = bus.req_be;
          if (bus.req_we) begin
            state_next = WR_SETUP;
            cnt_next   = WR_LOAD;
          end else begin
            state_next = RD;
            cnt_next   = RD_LOAD;
          end
        end
      end
      RD: begin
        if (cnt_reg == 4'd0) begin
          rdata_next     = SRAM_DQ;
          rsp_valid_next = 1'b1;
          state_next     = IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: begin
        if (cnt_reg == 4'd0) begin
          state_next = WR_HOLD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      WR_HOLD:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Strobes decode from registered state only. Write cycles keep CE_N low
  // and DQ driven one cycle either side of the WE_N pulse for setup/hold.
  always_comb begin
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_CE_N = 1'b1;
    dq_oe     = 1'b0;
    case (state_reg)
      RD: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
      end
      WR_SETUP, WR_PULSE, WR_HOLD: begin
        SRAM_CE_N = 1'b0;
        SRAM_UB_N = ~be_reg[1];
        SRAM_LB_N = ~be_reg[0];
        SRAM_WE_N = (state_reg == WR_PULSE) ? 1'b0 : 1'b1;
        dq_oe     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= 18'd0;
      wdata_reg     <= 16'd0;
      be_reg        <= 2'b00;
      rdata_reg     <= 16'd0;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      be_reg        <= be_next;
      rdata_reg     <= rdata_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

  assign SRAM_ADDR = addr_reg;
  assign SRAM_DQ   = dq_oe ? wdata_reg : 16'hzzzz;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_sram_ctrl
// Directed bench for mem_sram_ctrl with a behavioural asynchronous SRAM.
// A pull-up on the data bus makes an undriven DQ read as 16'hFFFF.
// ---------------------------------------------------------------------------
module tb_mem_sram_ctrl;
  logic        CLOCK_50;
  logic        reset;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ub_n, lb_n, ce_n;

  mem_sram_ctrl_if bus_if ();

  logic [15:0] sram_mem [0:255] = '{1: 16'hAAAA, 2: 16'h5555, 3: 16'h0F0F,
                                    5: 16'h7777, default: 16'h0000};
  logic [15:0] ref_mem  [0:255] = '{default: 16'h0000};

  int n_checks    = 0;
  int n_fail      = 0;
  int overlap_cnt = 0;

  mem_sram_ctrl #(.RD_WAIT(2), .WR_WAIT(2)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .bus       (bus_if),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (we_n),
    .SRAM_OE_N (oe_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_CE_N (ce_n)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // SRAM model
  pullup (sram_dq);
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr[7:0]] : 16'hzzzz;

  always @(posedge CLOCK_50) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) sram_mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!ub_n) sram_mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  always @(negedge CLOCK_50) begin
    if (!oe_n && !we_n) overlap_cnt++;
  end

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one write from IDLE and follows it until the controller is ready again.
  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be,
                          input bit scr, output int occ, output int we_low,
                          output logic [1:0] ublb_pulse, output bit bus_ok, output bit lane_ok);
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b1;
    bus_if.req_addr  = a;
    bus_if.req_wdata = d;
    bus_if.req_be    = be;
    tick();
    bus_if.req_valid = 1'b0;
    occ = 0; we_low = 0; ublb_pulse = 2'b11; bus_ok = 1'b1; lane_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bus_if.req_ready) break;
      if (scr) begin
        bus_if.req_addr  = 18'($urandom);
        bus_if.req_wdata = 16'($urandom);
        bus_if.req_be    = 2'($urandom);
      end
      occ++;
      if (!we_n) begin
        we_low++;
        ublb_pulse = {ub_n, lb_n};
      end
      if (sram_addr !== a || sram_dq !== d || ce_n !== 1'b0 || oe_n !== 1'b1) bus_ok = 1'b0;
      if ({ub_n, lb_n} !== ~be) lane_ok = 1'b0;
      tick();
    end
    $display("wr addr=%05h data=%04h be=%b occ=%0d we_low=%0d", a, d, be, occ, we_low);
  endtask

  // Issues one read from IDLE; returns in the cycle rsp_valid is seen.
  task automatic do_read(input logic [17:0] a, input bit scr, output logic [15:0] rd,
                         output int lat, output bit bus_ok);
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = a;
    bus_if.req_be    = 2'($urandom);
    tick();
    bus_if.req_valid = 1'b0;
    lat = 0; rd = 16'h0000; bus_ok = 1'b1;
    for (int cur = 1; cur <= 20; cur++) begin
      if (scr) begin
        bus_if.req_addr  = 18'($urandom);
        bus_if.req_wdata = 16'($urandom);
      end
      if (bus_if.rsp_valid) begin
        lat = cur;
        rd  = bus_if.rsp_rdata;
        break;
      end
      if (sram_addr !== a || {we_n, oe_n, ub_n, lb_n, ce_n} !== 5'b10000) bus_ok = 1'b0;
      tick();
    end
    $display("rd addr=%05h data=%04h latency=%0d", a, rd, lat);
  endtask

  initial begin : main
    int          occ, we_low, lat, pulses, idx, rand_err;
    logic [1:0]  ublb;
    logic [15:0] rd, d;
    logic [17:0] a;
    logic [1:0]  be;
    bit          bus_ok, lane_ok, z_ok;
    int          acc_cyc [3];
    logic [15:0] rsp_q [$];

    reset            = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = 18'd0;
    bus_if.req_wdata = 16'd0;
    bus_if.req_be    = 2'b00;
    tick();
    tick();
    check("ready_low_in_reset", 32'(bus_if.req_ready), 32'd0);
    reset = 1'b0;

    // Reset in the middle of a write
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b1;
    bus_if.req_addr  = 18'h00020;
    bus_if.req_wdata = 16'h5A5A;
    bus_if.req_be    = 2'b11;
    tick();
    bus_if.req_valid = 1'b0;
    tick();
    check("pre_reset_we_low", 32'(we_n), 32'd0);
    reset = 1'b1;
    tick();
    check("rst_strobes", 32'({we_n, oe_n, ub_n, lb_n, ce_n}), 32'h1F);
    check("rst_dq_z", 32'(sram_dq), 32'hFFFF);
    check("rst_ready", 32'(bus_if.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_rdata", 32'(bus_if.rsp_rdata), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("ready_after_reset", 32'(bus_if.req_ready), 32'd1);

    // Reset during a read: no response may appear
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = 18'h00001;
    tick();
    bus_if.req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus_if.rsp_valid) pulses++;
      tick();
    end
    check("abort_no_rsp", 32'(pulses), 32'd0);

    // Write then read, with req_* scrambled while the write is in flight
    do_write(18'h00010, 16'hBEEF, 2'b11, 1'b1, occ, we_low, ublb, bus_ok, lane_ok);
    check("wr1_we_low", 32'(we_low), 32'd2);
    check("wr1_occupancy", 32'(occ), 32'd4);
    check("wr1_bus_stable", 32'(bus_ok), 32'd1);
    check("wr1_lanes", 32'(lane_ok), 32'd1);
    check("idle_addr_hold", 32'(sram_addr), 32'h00010);
    do_read(18'h00010, 1'b1, rd, lat, bus_ok);
    check("rd1_latency", 32'(lat), 32'd3);
    check("rd1_data", 32'(rd), 32'hBEEF);
    check("rd1_bus", 32'(bus_ok), 32'd1);
    check("rd1_ready_with_rsp", 32'(bus_if.req_ready), 32'd1);

    // Lower-byte-only write
    do_write(18'h00010, 16'h1234, 2'b01, 1'b0, occ, we_low, ublb, bus_ok, lane_ok);
    check("wr2_ub_lb", 32'(ublb), 32'b10);
    check("wr2_lanes", 32'(lane_ok), 32'd1);
    do_read(18'h00010, 1'b0, rd, lat, bus_ok);
    check("rd2_data", 32'(rd), 32'hBE34);

    // Null write: full timing, no lanes enabled
    do_write(18'h00005, 16'h1111, 2'b00, 1'b0, occ, we_low, ublb, bus_ok, lane_ok);
    check("null_occupancy", 32'(occ), 32'd4);
    check("null_ub_lb", 32'(ublb), 32'b11);
    check("null_lanes", 32'(lane_ok), 32'd1);
    check("rdata_held", 32'(bus_if.rsp_rdata), 32'hBE34);
    do_read(18'h00005, 1'b0, rd, lat, bus_ok);
    check("null_rd_data", 32'(rd), 32'h7777);
    tick();

    // Back-to-back reads with req_valid held high
    idx = 0;
    z_ok = 1'b1;
    acc_cyc = '{default: 0};
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = 18'd1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      bit acc;
      acc = bus_if.req_ready && bus_if.req_valid;
      if (bus_if.rsp_valid) begin
        rsp_q.push_back(bus_if.rsp_rdata);
        $display("b2b rsp data=%04h cycle=%0d", bus_if.rsp_rdata, cyc);
      end
      if (oe_n && sram_dq !== 16'hFFFF) z_ok = 1'b0;
      tick();
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) bus_if.req_addr = 18'(idx + 1);
        else bus_if.req_valid = 1'b0;
      end
    end
    check("b2b_accepts", 32'(idx), 32'd3);
    check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    check("b2b_rsp_count", 32'(rsp_q.size()), 32'd3);
    if (rsp_q.size() == 3) begin
      check("b2b_data0", 32'(rsp_q[0]), 32'hAAAA);
      check("b2b_data1", 32'(rsp_q[1]), 32'h5555);
      check("b2b_data2", 32'(rsp_q[2]), 32'h0F0F);
    end
    check("b2b_dq_not_driven", 32'(z_ok), 32'd1);

    // Random requests with scrambled inputs against a reference memory
    rand_err = 0;
    for (int n = 0; n < 1000; n++) begin
      a  = 18'(8'h40 + $urandom_range(0, 191));
      d  = 16'($urandom);
      be = 2'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, d, be, 1'b1, occ, we_low, ublb, bus_ok, lane_ok);
        if (be[1]) ref_mem[a[7:0]][15:8] = d[15:8];
        if (be[0]) ref_mem[a[7:0]][7:0]  = d[7:0];
        if (occ != 4 || we_low != 2 || !bus_ok || !lane_ok) rand_err++;
      end else begin
        do_read(a, 1'b1, rd, lat, bus_ok);
        if (lat != 3 || !bus_ok || rd !== ref_mem[a[7:0]]) rand_err++;
      end
    end
    check("rand_errors", 32'(rand_err), 32'd0);
    check("oe_we_overlap", 32'(overlap_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
